// File: rtl/pipe_pkg.sv
// pipe_pkg: PIPE power-state codes plus types and constants for the PHY detect responder.
package pipe_pkg;
    localparam logic [2:0] P0 = 3'd0;
    localparam logic [2:0] P1 = 3'd1;
    localparam logic [2:0] P2 = 3'd2;
    localparam logic [2:0] P3 = 3'd3;

    localparam logic [2:0] RXS_NONE     = 3'b000;
    localparam logic [2:0] RXS_DETECTED = 3'b011;
    localparam logic [2:0] RXS_DET_ERR  = 3'b100;

    typedef enum logic [2:0] {
        ST_RST,
        ST_IDLE,
        ST_PD_WAIT,
        ST_PD_ACK,
        ST_DET_WAIT,
        ST_DET_ACK,
        ST_DET_HOLD
    } phy_resp_st;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction
endpackage

// File: rtl/pipe_phy_detect_resp.sv
// pipe_phy_detect_resp: PHY-side responder for PIPE receiver detection and PowerDown handshakes.
// Define DET_ERR_INJ_EN to let i_det_err force RxStatus=100 in the detect result.
module pipe_phy_detect_resp
    import pipe_pkg::*;
#(
    parameter int RST_CYCLES = 16,
    parameter int PD_LAT     = 4,
    parameter int DET_LAT    = 8
) (
    input  logic       i_core_clk,
    input  logic       i_rstn,
    input  logic [2:0] PowerDown,
    input  logic       TxDetectRxorLpbk,
    input  logic       i_far_end_present,
    input  logic       i_det_err,
    output logic       PhyStatus,
    output logic [2:0] RxStatus,
    output logic       RxElecIdle,
    output logic       o_busy
);
    localparam int CW = $clog2(max3(RST_CYCLES, PD_LAT, DET_LAT) + 1);

    phy_resp_st    st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_dec;
    logic [2:0]    pd_q, pd_d, pd_new_q, pd_new_d, rxstatus_q, rxstatus_d, det_res;
    logic          txd_q, det_edge, phystatus_q, phystatus_d, rxelecidle_q, busy_q, busy_d;

    assign det_edge = TxDetectRxorLpbk & ~txd_q;
    assign cnt_dec  = (cnt_q == '0) ? '0 : cnt_q - CW'(1);

`ifdef DET_ERR_INJ_EN
    assign det_res = i_det_err ? RXS_DET_ERR : (i_far_end_present ? RXS_DETECTED : RXS_NONE);
`else
    logic unused_det_err;
    assign unused_det_err = i_det_err;
    assign det_res = i_far_end_present ? RXS_DETECTED : RXS_NONE;
`endif

    always_ff @(posedge i_core_clk) begin
        if (!i_rstn) begin
            st_q         <= ST_RST;
            cnt_q        <= CW'(RST_CYCLES);
            pd_q         <= P1;
            pd_new_q     <= P1;
            txd_q        <= 1'b0;
            phystatus_q  <= 1'b1;
            rxstatus_q   <= RXS_NONE;
            rxelecidle_q <= 1'b1;
            busy_q       <= 1'b1;
        end else begin
            st_q         <= st_d;
            cnt_q        <= cnt_d;
            pd_q         <= pd_d;
            pd_new_q     <= pd_new_d;
            txd_q        <= TxDetectRxorLpbk;
            phystatus_q  <= phystatus_d;
            rxstatus_q   <= rxstatus_d;
            rxelecidle_q <= ~i_far_end_present;
            busy_q       <= busy_d;
        end
    end

    // A PowerDown mismatch outranks a detect edge; that edge is consumed by txd_q and lost.
    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        pd_new_d = pd_new_q;
        case (st_q)
            ST_RST: begin
                cnt_d = cnt_dec;
                st_d  = (cnt_q <= CW'(1)) ? ST_IDLE : ST_RST;
            end
            ST_IDLE: begin
                if (PowerDown != pd_q) begin
                    st_d     = ST_PD_WAIT;
                    cnt_d    = CW'(PD_LAT - 1);
                    pd_new_d = PowerDown;
                end else if (det_edge && pd_q == P1) begin
                    st_d  = ST_DET_WAIT;
                    cnt_d = CW'(DET_LAT - 1);
                end
            end
            ST_PD_WAIT: begin
                cnt_d = cnt_dec;
                st_d  = (cnt_q == '0) ? ST_PD_ACK : ST_PD_WAIT;
            end
            ST_PD_ACK: st_d = ST_IDLE;
            ST_DET_WAIT: begin
                cnt_d = cnt_dec;
                st_d  = !TxDetectRxorLpbk ? ST_IDLE : (cnt_q == '0) ? ST_DET_ACK : ST_DET_WAIT;
            end
            ST_DET_ACK:  st_d = ST_DET_HOLD;
            ST_DET_HOLD: st_d = TxDetectRxorLpbk ? ST_DET_HOLD : ST_IDLE;
            default:     st_d = ST_IDLE;
        endcase
    end

    always_comb begin
        phystatus_d = (st_q == ST_RST && cnt_q > CW'(1)) || st_q == ST_PD_ACK || st_q == ST_DET_ACK;
        rxstatus_d  = (st_q == ST_DET_ACK) ? det_res : RXS_NONE;
        pd_d        = (st_q == ST_PD_ACK) ? pd_new_q : pd_q;
        busy_d      = st_d != ST_IDLE;
    end

    assign PhyStatus  = phystatus_q;
    assign RxStatus   = rxstatus_q;
    assign RxElecIdle = rxelecidle_q;
    assign o_busy     = busy_q;
endmodule
